// File: rtl/instr_entry.sv
// instr_entry -- front-end instruction entry unit for the bit-serial CPU.
//
// A raw push-button is synchronized and debounced; each debounced rising
// edge captures the switch bank into a staging byte. Two captures (high
// byte, then low byte) form a 16-bit instruction that is issued to the core
// as registered opcode/instr with a one-cycle inst_done pulse.
//
// Ports:
//   clk        in   1   sole clock
//   rst        in   1   synchronous, active-high reset
//   sw         in   8   switch bank, sampled only on capture cycles
//   btn        in   1   raw, bouncing, asynchronous push-button
//   opcode     out  4   issued instruction bits [15:12]
//   instr      out  12  issued instruction bits [11:0]
//   inst_done  out  1   one-cycle pulse: new opcode/instr are valid
//   btn_edge   out  1   one-cycle pulse per debounced rising edge of btn
//   phase      out  2   entry state (0 WAIT_HI, 1 WAIT_LO, 2 ISSUE)
//
// Handshake: inst_done is a valid-only strobe with no ready; the core must
// accept opcode/instr in the cycle inst_done is high. The values then hold
// until the next issue, so a late reader still sees the last instruction.
module instr_entry #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SYNC_STAGES     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  sw,
  input  logic        btn,
  output logic [3:0]  opcode,
  output logic [11:0] instr,
  output logic        inst_done,
  output logic        btn_edge,
  output logic [1:0]  phase
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_HI = 2'd0,
    WAIT_LO = 2'd1,
    ISSUE   = 2'd2
  } state_e;

  // Synchronizer and debouncer
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   btn_s;
  logic                   deb_q, deb_d;
  logic                   deb_dly_q;
  logic [CW-1:0]          cnt_q, cnt_d;

  // Entry FSM and staging / output registers
  state_e      state_q, state_d;
  logic [7:0]  hi_q, hi_d;
  logic [7:0]  lo_q, lo_d;
  logic [15:0] out_q, out_d;
  logic        done_q, done_d;

  assign btn_s = sync_q[SYNC_STAGES-1];

  // Debounce: any sample agreeing with the current level restarts the count,
  // so only an unbroken run of DEBOUNCE_CYCLES disagreeing samples flips deb.
  always_comb begin
    deb_d = deb_q;
    cnt_d = cnt_q;
    if (btn_s == deb_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      deb_d = btn_s;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign btn_edge = deb_q & ~deb_dly_q;

  // Next-state and register loads. The output word is loaded from hi and the
  // live switch value on the same edge that captures lo, so the new
  // instruction is visible during the ISSUE cycle itself.
  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    out_d   = out_q;
    done_d  = 1'b0;
    case (state_q)
      WAIT_HI: begin
        if (btn_edge) begin
          hi_d    = sw;
          state_d = WAIT_LO;
        end
      end
      WAIT_LO: begin
        if (btn_edge) begin
          lo_d    = sw;
          out_d   = {hi_q, sw};
          done_d  = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // A debounced edge needs at least two cycles, so none can land here.
        state_d = WAIT_HI;
      end
      default: begin
        state_d = WAIT_HI;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= '0;
      deb_q     <= 1'b0;
      deb_dly_q <= 1'b0;
      cnt_q     <= '0;
      state_q   <= WAIT_HI;
      hi_q      <= '0;
      lo_q      <= '0;
      out_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], btn};
      deb_q     <= deb_d;
      deb_dly_q <= deb_q;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      out_q     <= out_d;
      done_q    <= done_d;
    end
  end

  assign opcode    = out_q[15:12];
  assign instr     = out_q[11:0];
  assign inst_done = done_q;
  assign phase     = state_q;

endmodule

// File: doc/instr_entry.md
# instr_entry

Front-end instruction entry unit for the bit-serial CPU. It turns a raw push-button and an 8-bit switch bank into the `opcode`/`instr`/`inst_done`/`btn_edge` signals consumed by `cpu_core`. The button input is synchronized and debounced. A 16-bit instruction is collected as two byte entries, then issued to the core with a one-cycle `inst_done` pulse.

## Interface
- `DEBOUNCE_CYCLES`, 16: consecutive stable synchronized samples needed before the debounced level changes (min 2).
- `SYNC_STAGES`, 2: flip-flop stages in the button synchronizer (min 2).

- `clk`  in  1  sole clock.
- `rst`  in  1  reset, synchronous, active-high.
- `sw`  in  8  switch bank, sampled only at capture cycles (assumed quasi-static).
- `btn`  in  1  raw, bouncing, asynchronous push-button.
- `opcode`  out  4  issued opcode; instruction bits [15:12].
- `instr`  out  12  issued operand field; instruction bits [11:0].
- `inst_done`  out  1  one-cycle pulse: a new instruction is valid on `opcode`/`instr`.
- `btn_edge`  out  1  one-cycle pulse on every debounced rising edge of `btn`.
- `phase`  out  2  entry state: 0 = WAIT_HI, 1 = WAIT_LO, 2 = ISSUE; 3 is never driven.

## Operation
- **Synchronizer:** `btn` passes through a `SYNC_STAGES`-deep flop chain. The last stage is `btn_s`.
- **Debouncer:**
  - Holds register `deb` and counter `cnt`, sized ceil(log2(DEBOUNCE_CYCLES)) bits.
  - If `btn_s == deb`, `cnt` is cleared to 0.
  - Otherwise `cnt` increments. When `cnt == DEBOUNCE_CYCLES-1`, `deb` takes `btn_s` and `cnt` clears.
  - A mismatch lasting fewer than `DEBOUNCE_CYCLES` cycles never changes `deb`.
- **Edge detect:**
  - `deb_d` is `deb` delayed one cycle; `btn_edge` = `deb & ~deb_d`.
  - A falling edge produces no pulse.
- **FSM and staging registers:**
  - Staging registers are `hi[7:0]` and `lo[7:0]`.
  - WAIT_HI: on `btn_edge`, `hi <= sw`, go to WAIT_LO.
  - WAIT_LO: on `btn_edge`, `lo <= sw`, go to ISSUE.
  - ISSUE: unconditionally return to WAIT_HI after one cycle. `btn_edge` cannot occur here, because `deb` needs ≥ 2 cycles of debounce.
- **Output registers:**
  - `{opcode, instr}` are registered. They load `{hi, lo}` on the clock edge that enters ISSUE.
  - `inst_done` is registered, high exactly during the ISSUE cycle.
  - Outputs therefore change only in the same cycle `inst_done` rises, and hold through the next entry.
- `btn_edge` is exported unconditionally in every state (the core also uses it as a step input).
- `phase` is a direct copy of the state register.

## Timing
- **Reset values** (all outputs and internal state, at the first `clk` edge with `rst` = 1):
  - `opcode` = 0, `instr` = 0, `inst_done` = 0, `btn_edge` = 0, `phase` = 0.
  - Synchronizer = 0, `deb` = 0, `deb_d` = 0, `cnt` = 0, `hi` = 0, `lo` = 0.
- **Reset mid-entry:** a partially entered instruction is discarded. No `inst_done` is issued. The next `btn_edge` captures the high byte.
- **Button held through reset:** `deb` = 0, so a button still held after reset yields one `btn_edge` after the normal latency. It is treated as a real press.
- **Button latency:** raw `btn` goes stable high and is first sampled at edge E0. `btn_s` is high after edge E0+SYNC_STAGES-1. `deb` rises after edge E0+SYNC_STAGES+DEBOUNCE_CYCLES-1. `btn_edge` is high for exactly that one following cycle.
- **Issue latency:** the `btn_edge` cycle in WAIT_LO is followed by exactly one ISSUE cycle. In that cycle `inst_done` = 1, new `opcode`/`instr` are valid, and `phase` = 2.
- **Minimum spacing:** two `btn_edge` pulses are at least 2·DEBOUNCE_CYCLES cycles apart (a release must also debounce).

## Test plan
- **Reset:** assert `rst` for 3 cycles with `btn`=1 and `sw`=FF, then deassert → during reset all outputs read 0. After release, `btn_edge` pulses once at the specified latency and `phase` goes 0→1.
- **Glitch rejection:** with DEBOUNCE_CYCLES=16, a `btn` high pulse of 15 cycles → no `btn_edge`, `phase` stays 0. Then 16 stable cycles → one pulse.
- **Bounce:** 5 high/low toggles of 3 cycles each, then steady high for 40 cycles → exactly one `btn_edge`. Release with bounce → no pulse.
- **Full entry:** press with `sw`=A5, press with `sw`=3C → one-cycle `inst_done` with `opcode`=A, `instr`=53C. Outputs hold while `sw` changes to 00 and a third press occurs (`phase`=1, no `inst_done`).
- **Back-to-back instructions:** enter 12/34, then 56/78 → two `inst_done` pulses. Outputs read 1/234, then 5/678. `btn_edge` count = 4.
- **Reset mid-entry:** press with `sw`=FF, assert `rst`, then enter 01/02 → `inst_done` once, `opcode`=0, `instr`=102.
